// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin burst arbiter that shares one async-FIFO
// read port among NREQ consumers. It drives the pop strobe into the read
// controller and returns each popped word to the consumer that owns the grant.
// Optional build macro: FIFO_ARB_PRIO0_EN. When it is defined, consumer 0 has
// absolute priority in IDLE, and the others are served round-robin.
module fifo_read_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic                  rempty_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  rinc_o,
  output logic [NREQ-1:0]       gnt_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [NREQ-1:0]       dvalid_o,
  output logic                  busy_o
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q;
  logic [NREQ-1:0]       gnt_q;
  logic [IDXW-1:0]       last_q;
  logic [CNTW-1:0]       cnt_q;
  logic [CNTW-1:0]       cnt_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [NREQ-1:0]       dvalid_q;

  logic [IDXW-1:0]       g_idx;
  logic                  req_g;
  logic                  rinc;
  logic                  burst_exit;
  logic                  win_found;
  logic [IDXW-1:0]       win_idx;
  logic [IDXW-1:0]       cand_idx;

  // Decode the one-hot grant into the index of the consumer being served.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) g_idx = IDXW'(i);
    end
  end

  // The pop strobe is allowed only while the granted consumer still asks and the FIFO has data.
  always_comb begin
    req_g      = req_i[g_idx];
    rinc       = (state_q == BURST) && req_g && !rempty_i;
    cnt_d      = cnt_q + CNTW'(rinc);
    burst_exit = !req_g || rempty_i || (rinc && (cnt_q == CNTW'(MAX_BURST - 1)));
  end

  // Pick the next winner. The scan starts one past the last served consumer.
  // In priority mode, consumer 0 wins first. If req 0 is low, the scan never selects index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
`ifdef FIFO_ARB_PRIO0_EN
    if (req_i[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IDXW'((int'(last_q) + k) % NREQ);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Arbitration FSM with the grant, the returned data and the round-robin pointer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= IDXW'(NREQ - 1);
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dvalid_q <= '0;
          if ((|req_i) && !rempty_i && win_found) begin
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          cnt_q <= cnt_d;
          if (rinc) begin
            dout_q   <= rdata_i;
            dvalid_q <= gnt_q;
          end else begin
            dvalid_q <= '0;
          end
          if (burst_exit) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
`ifdef FIFO_ARB_PRIO0_EN
            if (g_idx != '0) last_q <= g_idx;
`else
            last_q  <= g_idx;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rinc_o   = rinc;
  assign gnt_o    = gnt_q;
  assign dout_o   = dout_q;
  assign dvalid_o = dvalid_q;
  assign busy_o   = (state_q == BURST);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Testbench for fifo_read_arbiter.
// The read FIFO is modelled as a queue.
// A cycle-level reference model of the arbitration rules predicts gnt, busy and rinc.
// It pushes each expected pop (consumer, word) into a scoreboard.
// A monitor then matches the scoreboard against every dvalid pulse.
module tb_fifo_read_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 8;

  logic          rclk;
  logic          rrst_n;
  logic [NREQ-1:0] req_i;
  logic          rempty_i;
  logic [DW-1:0] rdata_i;
  logic          rinc_o;
  logic [NREQ-1:0] gnt_o;
  logic [DW-1:0] dout_o;
  logic [NREQ-1:0] dvalid_o;
  logic          busy_o;

  fifo_read_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .req_i(req_i), .rempty_i(rempty_i),
    .rdata_i(rdata_i), .rinc_o(rinc_o), .gnt_o(gnt_o), .dout_o(dout_o),
    .dvalid_o(dvalid_o), .busy_o(busy_o)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int passed = 0;

  // The environment FIFO, plus the scoreboard of expected returns.
  logic [DW-1:0] fifo_q[$];
  int            sb_who[$];
  logic [DW-1:0] sb_dat[$];
  logic          pend_pop = 1'b0;
  logic [DW-1:0] wr_word = '0;
  logic [NREQ-1:0] req_v = '0;

  // Reference model state. owner = -1 means no consumer holds the port.
  int owner  = -1;
  int m_last = NREQ - 1;
  int m_cnt  = 0;
  int n_pops = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endfunction

  function automatic int pick(logic [NREQ-1:0] r);
`ifdef FIFO_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_word();
    fifo_q.push_back(wr_word);
    wr_word = wr_word + 8'd1;
  endtask

  // One clock cycle, entered at a negedge and left at the next negedge.
  task automatic step();
    logic [NREQ-1:0] exp_gnt;
    logic            exp_rinc;
    logic            empty;
    if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pend_pop = 1'b0;
    empty    = (fifo_q.size() == 0);
    req_i    = req_v;
    rempty_i = empty;
    rdata_i  = empty ? DW'($urandom) : fifo_q[0];
    #1;
    exp_gnt  = (owner >= 0) ? NREQ'(1) << owner : '0;
    exp_rinc = (owner >= 0) && req_v[owner] && !empty;
    check("gnt", 32'(gnt_o), 32'(exp_gnt));
    check("busy", 32'(busy_o), 32'(owner >= 0));
    check("rinc", 32'(rinc_o), 32'(exp_rinc));
    if (exp_rinc) begin
      sb_who.push_back(owner);
      sb_dat.push_back(fifo_q[0]);
      n_pops++;
    end
    pend_pop = rinc_o;
    // Next-state prediction, written from the arbitration rules.
    if (owner < 0) begin
      if (|req_v && !empty) begin
        owner = pick(req_v);
        m_cnt = 0;
      end
    end else if (!req_v[owner] || empty || (exp_rinc && m_cnt == MB - 1)) begin
`ifdef FIFO_ARB_PRIO0_EN
      if (owner != 0) m_last = owner;
`else
      m_last = owner;
`endif
      owner = -1;
      m_cnt = 0;
    end else begin
      m_cnt += int'(exp_rinc);
    end
    @(negedge rclk);
  endtask

  // Monitor: every dvalid pulse must match the oldest scoreboard entry.
  always @(posedge rclk) begin
    #1;
    if (rrst_n && dvalid_o != '0) begin
      if (sb_who.size() == 0) begin
        check("dvalid_unexpected", 32'(dvalid_o), 32'h0);
      end else begin
        check("dvalid", 32'(dvalid_o), 32'(NREQ'(1) << sb_who.pop_front()));
        check("dout", 32'(dout_o), 32'(sb_dat.pop_front()));
      end
    end
  end

  initial begin
    rrst_n = 1'b0; req_i = '0; rempty_i = 1'b1; rdata_i = '0;
    repeat (2) @(negedge rclk);
    check("rst_rinc", 32'(rinc_o), 32'h0);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_dout", 32'(dout_o), 32'h0);
    check("rst_dvalid", 32'(dvalid_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    rrst_n = 1'b1;
    repeat (3) step();

    // Single burst: 12 words for consumer 0, a full burst of 8 and then a burst of 4.
    repeat (12) push_word();
    req_v = 4'b0001;
    repeat (24) step();
    req_v = '0;
    step();
    $display("single burst: pops so far %0d", n_pops);

    // Round robin with all requesters active and the FIFO kept topped up.
    req_v = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      if (fifo_q.size() < 4) repeat (4) push_word();
      step();
    end
    req_v = '0;
    repeat (3) step();
    $display("round robin: pops so far %0d", n_pops);

    // Drain any leftover words so the FIFO starts empty. Then consumer 2 finds only 3 words.
    req_v = 4'b0001;
    while (fifo_q.size() > 0 && n_pops < 1000) step();
    req_v = '0;
    repeat (2) step();
    repeat (3) push_word();
    req_v = 4'b0100;
    repeat (8) step();
    req_v = '0;
    step();
    $display("empty mid-burst: pops so far %0d", n_pops);

    // Request drop after two pops.
    repeat (10) push_word();
    req_v = 4'b0010;
    repeat (3) step();
    req_v = '0;
    repeat (3) step();
    $display("req drop: pops so far %0d", n_pops);

    // Asynchronous reset in the middle of a burst for consumer 1.
    req_v = 4'b0010;
    repeat (3) step();
    if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pend_pop = 1'b0;
    #2;
    rrst_n = 1'b0;
    #1;
    check("arst_rinc", 32'(rinc_o), 32'h0);
    check("arst_gnt", 32'(gnt_o), 32'h0);
    check("arst_dvalid", 32'(dvalid_o), 32'h0);
    check("arst_busy", 32'(busy_o), 32'h0);
    owner = -1; m_last = NREQ - 1; m_cnt = 0;
    sb_who.delete(); sb_dat.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
    req_v = 4'b1111;
    step();
    step();
    check("post_reset_gnt", 32'(gnt_o), 32'h1);
    $display("async reset: pops so far %0d", n_pops);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req_v = NREQ'($urandom);
      if ($urandom_range(1) == 0) push_word();
      step();
    end
    req_v = '0;
    repeat (4) step();
    check("scoreboard_drained", 32'(sb_who.size()), 32'h0);
    $display("random: total pops %0d", n_pops);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
